// File: rtl/spi_bridge.sv
// spi_bridge: SPI mode-0 slave front end for instr_dcd; define SPI_MISO_HIZ_EN to tristate miso while deselected
module spi_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       byte_sync,
    output logic [7:0] data_in,
    input  logic [7:0] data_out
);
    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
    logic       sclk_d, cs_d;
    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_fall, cs_active;
    logic [7:0] rx_sr, tx_sr, rx_base, tx_base, rx_nx, tx_nx;
    logic [2:0] bit_cnt, cnt_base, cnt_nx;
    logic       first_done, fd_base, done;

    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign cs_s      = cs_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_active = ~cs_s;

    // a new chip-select window clears the frame state before any coincident shift applies
    assign rx_base  = cs_fall ? 8'h00 : rx_sr;
    assign tx_base  = cs_fall ? 8'h00 : tx_sr;
    assign cnt_base = cs_fall ? 3'd0 : bit_cnt;
    assign fd_base  = cs_fall ? 1'b0 : first_done;

    // shift engine: sample on sclk rise, advance or reload the response on sclk fall
    always_comb begin
        rx_nx  = (cs_active && sclk_rise) ? {rx_base[6:0], mosi_s} : rx_base;
        cnt_nx = (cs_active && sclk_rise) ? cnt_base + 3'd1 : cnt_base;
        tx_nx  = !(cs_active && sclk_fall) ? tx_base :
                 (cnt_base == 3'd0 && fd_base) ? data_out : {tx_base[6:0], 1'b0};
        done   = cs_active && sclk_rise && cnt_base == 3'd7;
    end

    // pin synchronizers plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    // frame state and the byte hand-off to instr_dcd
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sr      <= 8'h00;
            tx_sr      <= 8'h00;
            bit_cnt    <= 3'd0;
            first_done <= 1'b0;
            byte_sync  <= 1'b0;
            data_in    <= 8'h00;
        end else begin
            rx_sr      <= rx_nx;
            tx_sr      <= tx_nx;
            bit_cnt    <= cnt_nx;
            first_done <= fd_base | done;
            byte_sync  <= done;
            if (done) data_in <= rx_nx;
        end
    end

`ifdef SPI_MISO_HIZ_EN
    assign miso = cs_active ? tx_sr[7] : 1'bz;
`else
    assign miso = cs_active & tx_sr[7];
`endif
endmodule
